svc_rv_io_uart_tx: RTL and testbench

SVC_RV_IO_UART_TX -- requirements
Module: svc_rv_io_uart_tx

---
 rtl/svc_rv_io_uart_pkg.sv | 34 +++
 rtl/svc_rv_io_uart_fifo.sv | 75 +++++++
 rtl/svc_rv_io_uart_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_svc_rv_io_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_io_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : svc_rv_io_uart_pkg
//  Purpose  : Shared definitions for the io-mapped UART transmitter:
//             register offsets (address bits [3:2]), STATUS bit positions
//             and the transmit state machine encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package svc_rv_io_uart_pkg;

    // Register selects, compared against address bits [3:2]
    localparam logic [1:0] C_REG_TXDATA = 2'd0;
    localparam logic [1:0] C_REG_STATUS = 2'd1;
    localparam logic [1:0] C_REG_TXCNT  = 2'd2;

    // STATUS register bit positions
    localparam int C_STAT_BUSY    = 0;
    localparam int C_STAT_FULL    = 1;
    localparam int C_STAT_EMPTY   = 2;
    localparam int C_STAT_OVF     = 3;
    localparam int C_STAT_CNT_LSB = 8;
    localparam int C_STAT_CNT_MSB = 15;

    // Transmit state machine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage : svc_rv_io_uart_pkg
`default_nettype wire

// File: rtl/svc_rv_io_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : svc_rv_io_uart_fifo
//  Purpose  : Synchronous FIFO with first-word-fall-through read port.
//             A push while full and a pop while empty are ignored.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             push, push_data   - write strobe and data
//             pop, pop_data     - read strobe and current head entry
//             full, empty       - occupancy flags
//             count             - number of entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module svc_rv_io_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import svc_rv_io_uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : svc_rv_io_uart_fifo
`default_nettype wire

// File: rtl/svc_rv_io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : svc_rv_io_uart_tx
//  Purpose  : io-mapped 8N1 UART transmitter with a TX FIFO.
//             Registers (address bits [3:2]):
//               0 TXDATA  write byte lane 0 pushes a byte, reads 0
//               1 STATUS  {count[15:8], ovf, empty, full, busy}; write
//                         bit3 clears ovf
//               2 TXCNT   completed frame count (optional)
//               3         reads 0, writes ignored
//  Ports    : clk, rst                     - clock, sync active-high reset
//             io_raddr, io_rdata           - combinational read port
//             io_wen, io_waddr, io_wdata,
//             io_wstrb                     - write port
//             txd                          - serial output, idle high
//  Config   : define SVC_RV_IO_UART_TX_CNT_EN to include the 32-bit TXCNT
//             frame counter; otherwise TXCNT reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module svc_rv_io_uart_tx
    import svc_rv_io_uart_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     io_raddr,
    output logic [XLEN-1:0]     io_rdata,
    input  logic                io_wen,
    input  logic [XLEN-1:0]     io_waddr,
    input  logic [XLEN-1:0]     io_wdata,
    input  logic [XLEN/8-1:0]   io_wstrb,
    output logic                txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic w_wr_txdata;
    logic w_clr_ovf;
    logic w_ovf_set;

    assign w_wr_txdata = io_wen && (io_waddr[3:2] == C_REG_TXDATA) && io_wstrb[0];
    assign w_clr_ovf   = io_wen && (io_waddr[3:2] == C_REG_STATUS) && io_wstrb[0]
                         && io_wdata[C_STAT_OVF];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic              w_pop;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic [FCNT_W-1:0] w_count;

    svc_rv_io_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_wr_txdata),
        .push_data (io_wdata[7:0]),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Fullness is judged before any same-cycle pop: the byte is dropped.
    assign w_ovf_set = w_wr_txdata && w_full;

    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    uart_state_e      r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_idx, w_idx_n;
    logic [7:0]       r_shift, w_shift_n;
    logic             r_txd, w_txd_n;
    logic             w_cnt_last;
    logic             w_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_txd   <= w_txd_n;
        end
    end

    assign w_cnt_last = (r_cnt == BIT_LAST);

    // txd is registered from the current state, so the line lags the
    // state by one cycle; every bit still lasts CLKS_PER_BIT cycles.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_idx_n      = r_idx;
        w_shift_n    = r_shift;
        w_txd_n      = 1'b1;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_cnt_n   = '0;
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                w_txd_n = 1'b0;
                if (w_cnt_last) begin
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_state_n = ST_DATA;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                w_txd_n = r_shift[0];
                if (w_cnt_last) begin
                    w_cnt_n   = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_n = ST_STOP;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_cnt_last) begin
                    w_frame_done = 1'b1;
                    w_cnt_n      = '0;
                    // Chain straight into the next frame when data waits.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_state_n = ST_START;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign txd = r_txd;

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    logic [31:0] w_txcnt;
`ifdef SVC_RV_IO_UART_TX_CNT_EN
    logic [31:0] r_txcnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txcnt <= '0;
        end else if (w_frame_done) begin
            r_txcnt <= r_txcnt + 32'd1;
        end
    end
    assign w_txcnt = r_txcnt;
`else
    logic w_unused_frame_done;
    assign w_unused_frame_done = w_frame_done;
    assign w_txcnt = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_rdata = '0;
        case (io_raddr[3:2])
            C_REG_STATUS: begin
                io_rdata[C_STAT_BUSY]  = (r_state != ST_IDLE);
                io_rdata[C_STAT_FULL]  = w_full;
                io_rdata[C_STAT_EMPTY] = w_empty;
                io_rdata[C_STAT_OVF]   = r_ovf;
                io_rdata[C_STAT_CNT_MSB:C_STAT_CNT_LSB] = 8'(w_count);
            end
            C_REG_TXCNT: io_rdata = XLEN'(w_txcnt);
            default:     io_rdata = '0;
        endcase
    end

    // Only address bits [3:2], data byte 0 and byte lane 0 matter.
    logic w_unused_ok;
    assign w_unused_ok = ^{io_raddr[XLEN-1:4], io_raddr[1:0],
                           io_waddr[XLEN-1:4], io_waddr[1:0],
                           io_wdata[XLEN-1:8], io_wstrb[XLEN/8-1:1]};

endmodule : svc_rv_io_uart_tx
`default_nettype wire

// File: tb/tb_svc_rv_io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_svc_rv_io_uart_tx
//  Purpose  : Self-checking bench for svc_rv_io_uart_tx (10 clocks/bit,
//             4-entry FIFO). A frame-level reference model predicts txd and
//             every register read each cycle; a vector table and directed
//             sequences add fixed expectations.
//  Config   : honours SVC_RV_IO_UART_TX_CNT_EN for the TXCNT expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_svc_rv_io_uart_tx;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;
`ifdef SVC_RV_IO_UART_TX_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] io_raddr = '0;
    logic [XLEN-1:0] io_rdata;
    logic            io_wen = 1'b0;
    logic [XLEN-1:0] io_waddr = '0;
    logic [XLEN-1:0] io_wdata = '0;
    logic [3:0]      io_wstrb = '0;
    logic            txd;

    always #5 clk = ~clk;

    svc_rv_io_uart_tx #(
        .XLEN       (XLEN),
        .CLK_FREQ   (100),
        .BAUD       (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_raddr (io_raddr),
        .io_rdata (io_rdata),
        .io_wen   (io_wen),
        .io_waddr (io_waddr),
        .io_wdata (io_wdata),
        .io_wstrb (io_wstrb),
        .txd      (txd)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0]  q[$];          // bytes waiting in the FIFO
    bit          m_act = 0;     // a frame is in flight
    int          m_pos = 0;     // clocks since that frame's byte was taken
    logic [7:0]  m_cur = '0;
    bit          m_ovf = 0;
    logic [31:0] m_txcnt = '0;
    bit          m_txd = 1;
    bit          mvalid = 0;

    function automatic bit line_bit(input logic [7:0] b, input int p);
        if (p < CPB)          return 1'b0;
        else if (p < 9 * CPB) return b[(p - CPB) / CPB];
        else                  return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        case (a[3:2])
            2'd1: begin
                r[0]    = m_act;
                r[1]    = (q.size() == DEPTH);
                r[2]    = (q.size() == 0);
                r[3]    = m_ovf;
                r[15:8] = 8'(q.size());
            end
            2'd2:    r = CNT_EN ? m_txcnt : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void model_edge(input bit r, input bit w, input logic [31:0] wa,
                                       input logic [31:0] wd, input logic [3:0] ws);
        bit ending, can_pop, push_req, was_full, clr;
        if (r) begin
            q.delete();
            m_act = 0; m_pos = 0; m_ovf = 0; m_txcnt = '0; m_txd = 1; mvalid = 1;
            return;
        end
        m_txd    = m_act ? line_bit(m_cur, m_pos) : 1'b1;
        ending   = m_act && (m_pos == FRAME - 1);
        can_pop  = (q.size() != 0) && (!m_act || ending);
        push_req = w && (wa[3:2] == 2'd0) && ws[0];
        was_full = (q.size() == DEPTH);
        clr      = w && (wa[3:2] == 2'd1) && ws[0] && wd[3];
        if (ending) m_txcnt = m_txcnt + 32'd1;
        if (can_pop) begin
            m_cur = q.pop_front(); m_act = 1; m_pos = 0;
        end else if (ending) begin
            m_act = 0;
        end else if (m_act) begin
            m_pos++;
        end
        if (push_req && !was_full) q.push_back(wd[7:0]);
        if (push_req && was_full) m_ovf = 1;
        else if (clr)             m_ovf = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check model, then advance the model at the edge.
    // got_* return what the DUT showed before this cycle's edge.
    task automatic step(input bit r, input bit w, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] ra,
                        output logic [31:0] got_rd, output logic got_txd);
        @(negedge clk);
        rst = r; io_wen = w; io_waddr = wa; io_wdata = wd; io_wstrb = ws; io_raddr = ra;
        #1;
        got_rd  = io_rdata;
        got_txd = txd;
        if (mvalid) begin
            chk("model_rdata", io_rdata, exp_rd(ra));
            chk("model_txd", {31'd0, txd}, {31'd0, m_txd});
        end
        @(posedge clk);
        model_edge(r, w, wa, wd, ws);
    endtask

    task automatic idle(input int n, input logic [31:0] ra);
        logic [31:0] d; logic t;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ra, d, t);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic t;
        step(0, 1, a, d, s, 32'h4, rd, t);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] ra;
        logic [31:0] exp_rd;
        bit          exp_txd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd;
        logic        t;
        int          ones;
        int          pat[8];

        tbl[0]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h4,   1};
        tbl[1]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h0,  32'h0,   1};
        tbl[2]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'hC,  32'h0,   1};
        tbl[3]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h8,  32'h0,   1};
        tbl[4]  = '{0, 1, 32'hC, 32'hFF, 4'hF, 32'h4,  32'h4,   1};
        tbl[5]  = '{0, 1, 32'h0, 32'h55, 4'hE, 32'hC,  32'h0,   1};
        tbl[6]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h4,   1};
        tbl[7]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h4,   1};
        tbl[8]  = '{0, 1, 32'h0, 32'h3C, 4'h1, 32'h4,  32'h4,   1};
        tbl[9]  = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h100, 1};
        tbl[10] = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h14, 32'h5,   1};
        tbl[11] = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h5,   0};
        tbl[12] = '{0, 1, 32'h4, 32'h08, 4'h1, 32'h0,  32'h0,   0};
        tbl[13] = '{0, 0, 32'h0, 32'h00, 4'h0, 32'h4,  32'h5,   0};

        pat = '{1, 0, 1, 0, 0, 1, 0, 1};

        // Reset
        step(1, 0, 0, 0, 0, 32'h4, rd, t);
        step(1, 0, 0, 0, 0, 32'h4, rd, t);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].ra, rd, t);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_txd", i), {31'd0, t}, {31'd0, tbl[i].exp_txd});
        end
        idle(FRAME + 5, 32'h4);

        // 0xA5 frame shape
        wr(32'h0, 32'hA5, 4'h1);
        idle(2, 32'h4);
        for (int j = 0; j < FRAME; j++) begin
            step(0, 0, 0, 0, 0, 32'h4, rd, t);
            if (j < CPB)          chk($sformatf("a5_bit_c%0d", j), {31'd0, t}, 32'd0);
            else if (j < 9 * CPB) chk($sformatf("a5_bit_c%0d", j), {31'd0, t}, pat[(j - CPB) / CPB]);
            else                  chk($sformatf("a5_bit_c%0d", j), {31'd0, t}, 32'd1);
        end
        idle(5, 32'h4);

        // Three back-to-back frames, busy throughout
        ones = 0;
        for (int k = 0; k < 302; k++) begin
            if (k < 3) step(0, 1, 32'h0, 32'(k + 1), 4'h1, 32'h4, rd, t);
            else       step(0, 0, 0, 0, 0, 32'h4, rd, t);
            if (k >= 2 && rd[0]) ones++;
        end
        chk("b2b_busy_cycles", ones, 3 * FRAME);
        step(0, 0, 0, 0, 0, 32'h4, rd, t);
        chk("b2b_done_status", rd, 32'h4);

        // Overflow and clear
        for (int k = 0; k < 6; k++) wr(32'h0, 32'h10 + 32'(k), 4'h1);
        step(0, 0, 0, 0, 0, 32'h4, rd, t);
        chk("ovf_status", rd, 32'h40B);
        wr(32'h4, 32'h8, 4'h1);
        step(0, 0, 0, 0, 0, 32'h4, rd, t);
        chk("ovf_cleared", rd, 32'h403);
        idle(5 * FRAME + 10, 32'h4);

        // Reset mid-frame
        wr(32'h0, 32'h5A, 4'h1);
        wr(32'h0, 32'h77, 4'h1);
        idle(1 + 35, 32'h4);
        step(1, 0, 0, 0, 0, 32'h4, rd, t);
        step(0, 0, 0, 0, 0, 32'h4, rd, t);
        chk("rst_txd", {31'd0, t}, 32'd1);
        chk("rst_status", rd, 32'h4);
        step(0, 0, 0, 0, 0, 32'h8, rd, t);
        chk("rst_txcnt", rd, 32'h0);
        idle(3 * CPB, 32'h4);

        // Frame counter
        for (int k = 0; k < 3; k++) wr(32'h0, 32'hC0 + 32'(k), 4'h1);
        idle(3 * FRAME + 10, 32'h8);
        step(0, 0, 0, 0, 0, 32'h8, rd, t);
        chk("txcnt_after3", rd, CNT_EN ? 32'd3 : 32'd0);
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        step(0, 0, 0, 0, 0, 32'h8, rd, t);
        chk("txcnt_wr_ignored", rd, CNT_EN ? 32'd3 : 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            bit          r, w;
            logic [31:0] wa, wd, ra;
            logic [3:0]  ws;
            r  = ($urandom_range(0, 799) == 0);
            w  = ($urandom_range(0, 29) == 0);
            wa = $urandom();
            if ($urandom_range(0, 1) == 0) wa[3:2] = 2'd0;
            wd = $urandom();
            ws = 4'($urandom());
            ra = $urandom();
            step(r, w, wa, wd, ws, ra, rd, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_svc_rv_io_uart_tx
`default_nettype wire
